riscv_mem_responder: RTL and testbench

//  Memory-side responder for the riscv_cpu instruction and data memory ports.

---
 rtl/riscv_mem_pkg.sv | 21 ++
 rtl/riscv_mem_responder_if.sv | 31 +++
 rtl/riscv_dbg_fifo.sv | 66 ++++++
 rtl/riscv_mem_responder.sv | 148 ++++++++++++++
 tb/tb_riscv_mem_responder.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the riscv_cpu memory responder: MMIO register map,
// read-source selector and architectural constants.
package riscv_mem_pkg;

    localparam logic [31:0] RISCV_NOP         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hFFFF_0000;

    // Word index inside the 16-byte MMIO window (byte offset = index * 4)
    typedef enum logic [1:0] {
        MMIO_CYC_LO = 2'd0,
        MMIO_CYC_HI = 2'd1,
        MMIO_GPIO   = 2'd2,
        MMIO_DBG    = 2'd3
    } mmio_reg_e;

    typedef enum logic {
        RD_SRC_REG = 1'b0,
        RD_SRC_RAM = 1'b1
    } rd_src_e;

endpackage

// File: rtl/riscv_mem_responder_if.sv
// Instruction and data memory port bundle between riscv_cpu (master)
// and the memory responder (slave).
interface riscv_mem_responder_if;
    logic [31:0] instruction_memory_address;
    logic [31:0] instruction_memory_instruction;
    logic [31:0] data_memory_address;
    logic [31:0] data_memory_write_data;
    logic        data_memory_mem_write;
    logic        data_memory_mem_read;
    logic [31:0] data_memory_read_data;

    modport master (
        output instruction_memory_address,
        input  instruction_memory_instruction,
        output data_memory_address,
        output data_memory_write_data,
        output data_memory_mem_write,
        output data_memory_mem_read,
        input  data_memory_read_data
    );

    modport slave (
        input  instruction_memory_address,
        output instruction_memory_instruction,
        input  data_memory_address,
        input  data_memory_write_data,
        input  data_memory_mem_write,
        input  data_memory_mem_read,
        output data_memory_read_data
    );
endinterface

// File: rtl/riscv_dbg_fifo.sv
// Synchronous FIFO for the debug TX byte stream. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise it is dropped.
module riscv_dbg_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Occupancy flags and the accepted push/pop for this cycle
    always_comb begin
        empty_s   = (count_r == {(PW+1){1'b0}});
        full_s    = (count_r == (PW+1)'(DEPTH));
        do_pop_s  = pop & ~empty_s;
        do_push_s = push & (~full_s | do_pop_s);
    end

    // Storage, power-of-two wrapping pointers and occupancy counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/riscv_mem_responder.sv
// Memory-side responder for riscv_cpu: shared dual-port word RAM for fetch and
// data, plus an MMIO window with cycle counter, GPIO and debug TX FIFO.
module riscv_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 4096,
    parameter string       INIT_FILE  = "",
    parameter logic [31:0] MMIO_BASE  = DEFAULT_MMIO_BASE,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    riscv_mem_responder_if.slave        bus,
    output logic [31:0]                 gpio_out,
    output logic [7:0]                  dbg_tx_data,
    output logic                        dbg_tx_valid,
    input  logic                        dbg_tx_ready,
    output logic                        bus_error
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned HW = 30 - AW;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram_r [MEM_WORDS];
    logic [31:0]   ram_a_r;
    logic [31:0]   ram_b_r;

    logic [63:0]   cyc_cnt_r;
    logic [31:0]   cyc_shadow_r;
    logic [31:0]   gpio_r;
    logic [31:0]   mmio_rd_r;
    rd_src_e       rd_sel_r;
    logic          bus_err_r;
    logic          fetch_nop_r;

    logic          fetch_hit_s;
    logic          ram_hit_s;
    logic          mmio_hit_s;
    logic          bus_err_set_s;
    logic [AW-1:0] fetch_idx_s;
    logic [AW-1:0] data_idx_s;
    mmio_reg_e     mmio_reg_s;
    logic [31:0]   mmio_rdata_s;
    logic          gpio_we_s;
    logic          dbg_push_s;
    logic          shadow_le_s;

    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic [7:0]    fifo_head_s;
    logic          unused_addr_bits_s;

    assign unused_addr_bits_s = ^{bus.instruction_memory_address[1:0],
                                  bus.data_memory_address[1:0]};

    // Address decode for both ports and MMIO strobes
    always_comb begin
        fetch_hit_s   = (bus.instruction_memory_address[31:AW+2] == {HW{1'b0}});
        ram_hit_s     = (bus.data_memory_address[31:AW+2] == {HW{1'b0}});
        mmio_hit_s    = (bus.data_memory_address[31:4] == MMIO_BASE[31:4]);
        fetch_idx_s   = bus.instruction_memory_address[AW+1:2];
        data_idx_s    = bus.data_memory_address[AW+1:2];
        mmio_reg_s    = mmio_reg_e'(bus.data_memory_address[3:2]);
        gpio_we_s     = bus.data_memory_mem_write & mmio_hit_s & (mmio_reg_s == MMIO_GPIO);
        dbg_push_s    = bus.data_memory_mem_write & mmio_hit_s & (mmio_reg_s == MMIO_DBG);
        shadow_le_s   = mmio_hit_s & (mmio_reg_s == MMIO_CYC_LO);
        bus_err_set_s = ~fetch_hit_s |
                        ((bus.data_memory_mem_read | bus.data_memory_mem_write) &
                         ~ram_hit_s & ~mmio_hit_s);
    end

    // MMIO read mux, sampled from pre-edge state so a same-cycle write is not visible
    always_comb begin
        mmio_rdata_s = 32'h0000_0000;
        case (mmio_reg_s)
            MMIO_CYC_LO: mmio_rdata_s = cyc_cnt_r[31:0];
            MMIO_CYC_HI: mmio_rdata_s = cyc_shadow_r;
            MMIO_GPIO:   mmio_rdata_s = gpio_r;
            MMIO_DBG:    mmio_rdata_s = {27'd0, 4'(fifo_count_s), fifo_full_s};
            default:     mmio_rdata_s = 32'h0000_0000;
        endcase
    end

    // Dual-port RAM, read-first on both ports; contents survive reset
    always_ff @(posedge clk) begin
        if (bus.data_memory_mem_write && ram_hit_s) begin
            ram_r[data_idx_s] <= bus.data_memory_write_data;
        end
        ram_a_r <= ram_r[fetch_idx_s];
        if (bus.data_memory_mem_read) begin
            ram_b_r <= ram_r[data_idx_s];
        end
    end

    // Cycle counter, MMIO registers, read-source tracking and sticky bus error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_cnt_r    <= 64'd0;
            cyc_shadow_r <= 32'd0;
            gpio_r       <= 32'd0;
            mmio_rd_r    <= 32'd0;
            rd_sel_r     <= RD_SRC_REG;
            bus_err_r    <= 1'b0;
            fetch_nop_r  <= 1'b1;
        end else begin
            cyc_cnt_r   <= cyc_cnt_r + 64'd1;
            fetch_nop_r <= ~fetch_hit_s;
            if (bus_err_set_s) begin
                bus_err_r <= 1'b1;
            end
            if (gpio_we_s) begin
                gpio_r <= bus.data_memory_write_data;
            end
            if (bus.data_memory_mem_read) begin
                rd_sel_r  <= ram_hit_s ? RD_SRC_RAM : RD_SRC_REG;
                mmio_rd_r <= mmio_hit_s ? mmio_rdata_s : 32'd0;
                if (shadow_le_s) begin
                    cyc_shadow_r <= cyc_cnt_r[63:32];
                end
            end
        end
    end

    riscv_dbg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_dbg_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (dbg_push_s),
        .push_data (bus.data_memory_write_data[7:0]),
        .pop       (dbg_tx_ready),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .head      (fifo_head_s)
    );

    // Read data comes from the RAM output register or the MMIO/zero register
    assign bus.instruction_memory_instruction = fetch_nop_r ? RISCV_NOP : ram_a_r;
    assign bus.data_memory_read_data          = (rd_sel_r == RD_SRC_RAM) ? ram_b_r : mmio_rd_r;
    assign gpio_out     = gpio_r;
    assign bus_error    = bus_err_r;
    assign dbg_tx_valid = ~fifo_empty_s;
    assign dbg_tx_data  = fifo_head_s;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Self-checking bench for riscv_mem_responder: directed scenarios plus
// randomized RAM and FIFO traffic against a queue/array reference model.
module tb_riscv_mem_responder;
    localparam logic [31:0] BASE     = 32'hFFFF_0000;
    localparam logic [31:0] A_CYC_LO = BASE + 32'h0;
    localparam logic [31:0] A_CYC_HI = BASE + 32'h4;
    localparam logic [31:0] A_GPIO   = BASE + 32'h8;
    localparam logic [31:0] A_DBG    = BASE + 32'hC;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          DEPTH    = 8;

    logic        clk;
    logic        reset_n;
    logic [31:0] gpio_out;
    logic [7:0]  dbg_tx_data;
    logic        dbg_tx_valid;
    logic        dbg_tx_ready;
    logic        bus_error;

    int checks   = 0;
    int failures = 0;
    logic [31:0] ram_m [int unsigned];

    riscv_mem_responder_if mem_if ();

    riscv_mem_responder #(
        .MEM_WORDS  (4096),
        .INIT_FILE  (""),
        .MMIO_BASE  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (mem_if),
        .gpio_out     (gpio_out),
        .dbg_tx_data  (dbg_tx_data),
        .dbg_tx_valid (dbg_tx_valid),
        .dbg_tx_ready (dbg_tx_ready),
        .bus_error    (bus_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] addr, input logic rd, input logic wr,
                         input logic [31:0] wdata);
        mem_if.data_memory_address    = addr;
        mem_if.data_memory_mem_read   = rd;
        mem_if.data_memory_mem_write  = wr;
        mem_if.data_memory_write_data = wdata;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        dbg_tx_ready = 1'b0;
        mem_if.instruction_memory_address = 32'h0;
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        checks++; if (mem_if.instruction_memory_instruction !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", mem_if.instruction_memory_instruction, NOP); end
        checks++; if (mem_if.data_memory_read_data !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", mem_if.data_memory_read_data); end
        checks++; if (gpio_out !== 32'h0) begin failures++; $display("FAIL reset_gpio got=%h exp=0", gpio_out); end
        checks++; if (dbg_tx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dbg_tx_valid); end
        checks++; if (bus_error !== 1'b0) begin failures++; $display("FAIL reset_buserr got=%b exp=0", bus_error); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_store_load();
        drive(32'h10, 1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        drive(32'h10, 1'b1, 1'b0, 32'h0);
        mem_if.instruction_memory_address = 32'h10;
        tick();
        checks++; if (mem_if.data_memory_read_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_0x10 got=%h exp=deadbeef", mem_if.data_memory_read_data); end
        checks++; if (mem_if.instruction_memory_instruction !== 32'hDEAD_BEEF) begin failures++; $display("FAIL fetch_0x10 got=%h exp=deadbeef", mem_if.instruction_memory_instruction); end
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++; if (mem_if.data_memory_read_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rdata_hold got=%h exp=deadbeef", mem_if.data_memory_read_data); end
        ram_m[32'h10 >> 2] = 32'hDEAD_BEEF;
    endtask

    task automatic test_rw_same_cycle();
        drive(32'h20, 1'b0, 1'b1, 32'h5);
        tick();
        drive(32'h20, 1'b1, 1'b1, 32'h1);
        tick();
        checks++; if (mem_if.data_memory_read_data !== 32'h5) begin failures++; $display("FAIL rw_pre_write got=%h exp=5", mem_if.data_memory_read_data); end
        drive(32'h20, 1'b1, 1'b0, 32'h0);
        tick();
        checks++; if (mem_if.data_memory_read_data !== 32'h1) begin failures++; $display("FAIL rw_post_write got=%h exp=1", mem_if.data_memory_read_data); end
        // fetch and store hitting the same word
        drive(32'h30, 1'b0, 1'b1, 32'hAAAA_0001);
        tick();
        mem_if.instruction_memory_address = 32'h30;
        drive(32'h30, 1'b0, 1'b1, 32'hBBBB_0002);
        tick();
        checks++; if (mem_if.instruction_memory_instruction !== 32'hAAAA_0001) begin failures++; $display("FAIL fetch_pre_write got=%h exp=aaaa0001", mem_if.instruction_memory_instruction); end
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++; if (mem_if.instruction_memory_instruction !== 32'hBBBB_0002) begin failures++; $display("FAIL fetch_post_write got=%h exp=bbbb0002", mem_if.instruction_memory_instruction); end
    endtask

    task automatic test_random_ram();
        logic [31:0] exp_rd, exp_if, wd;
        int unsigned idx, fidx;
        logic do_rd, do_wr;
        exp_rd = 32'h0;
        for (int unsigned i = 64; i < 128; i++) begin
            wd = $urandom;
            drive(i << 2, 1'b0, 1'b1, wd);
            ram_m[i] = wd;
            tick();
        end
        for (int n = 0; n < 80; n++) begin
            idx   = $urandom_range(64, 127);
            fidx  = $urandom_range(64, 127);
            do_wr = 1'($urandom_range(0, 1));
            do_rd = (n == 0) || ($urandom_range(0, 2) != 0);
            wd    = $urandom;
            drive((idx << 2) | 32'($urandom_range(0, 3)), do_rd, do_wr, wd);
            mem_if.instruction_memory_address = (fidx << 2) | 32'($urandom_range(0, 3));
            exp_if = ram_m[fidx];
            if (do_rd) exp_rd = ram_m[idx];
            if (do_wr) ram_m[idx] = wd;
            tick();
            checks++; if (mem_if.data_memory_read_data !== exp_rd) begin failures++; $display("FAIL rand_load n=%0d got=%h exp=%h", n, mem_if.data_memory_read_data, exp_rd); end
            checks++; if (mem_if.instruction_memory_instruction !== exp_if) begin failures++; $display("FAIL rand_fetch n=%0d got=%h exp=%h", n, mem_if.instruction_memory_instruction, exp_if); end
        end
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        mem_if.instruction_memory_address = 32'h10;
    endtask

    task automatic test_gpio();
        logic [31:0] v1, v2;
        for (int n = 0; n < 4; n++) begin
            v1 = $urandom;
            v2 = $urandom;
            drive(A_GPIO, 1'b0, 1'b1, v1);
            tick();
            checks++; if (gpio_out !== v1) begin failures++; $display("FAIL gpio_write got=%h exp=%h", gpio_out, v1); end
            drive(A_GPIO, 1'b1, 1'b1, v2);
            tick();
            checks++; if (mem_if.data_memory_read_data !== v1) begin failures++; $display("FAIL gpio_read_pre got=%h exp=%h", mem_if.data_memory_read_data, v1); end
            checks++; if (gpio_out !== v2) begin failures++; $display("FAIL gpio_rw got=%h exp=%h", gpio_out, v2); end
            drive(A_CYC_HI, 1'b0, 1'b1, ~v2);
            tick();
            checks++; if (gpio_out !== v2) begin failures++; $display("FAIL gpio_ro_write got=%h exp=%h", gpio_out, v2); end
        end
        drive(32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_fifo_fill_drain();
        dbg_tx_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            drive(A_DBG, 1'b0, 1'b1, 32'h0000_0041 + 32'(k));
            tick();
        end
        drive(A_DBG, 1'b1, 1'b0, 32'h0);
        tick();
        checks++; if (mem_if.data_memory_read_data !== 32'h11) begin failures++; $display("FAIL dbg_status_full got=%h exp=11", mem_if.data_memory_read_data); end
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++; if (dbg_tx_valid !== 1'b1 || dbg_tx_data !== 8'h41) begin failures++; $display("FAIL dbg_stall got=%b/%h exp=1/41", dbg_tx_valid, dbg_tx_data); end
        dbg_tx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (dbg_tx_valid !== 1'b1 || dbg_tx_data !== 8'(8'h41 + k)) begin failures++; $display("FAIL dbg_drain k=%0d got=%b/%h exp=1/%h", k, dbg_tx_valid, dbg_tx_data, 8'(8'h41 + k)); end
            tick();
        end
        checks++; if (dbg_tx_valid !== 1'b0) begin failures++; $display("FAIL dbg_empty got=%b exp=0", dbg_tx_valid); end
    endtask

    task automatic test_fifo_random();
        logic [7:0]  q [$];
        logic        psh, rdy, stat, pop, full_pre;
        logic [7:0]  b;
        logic [31:0] exp_stat;
        for (int n = 0; n < 160; n++) begin
            checks++; if (dbg_tx_valid !== (q.size() != 0)) begin failures++; $display("FAIL frand_valid n=%0d got=%b exp=%b", n, dbg_tx_valid, q.size() != 0); end
            if (q.size() != 0) begin
                checks++; if (dbg_tx_data !== q[0]) begin failures++; $display("FAIL frand_data n=%0d got=%h exp=%h", n, dbg_tx_data, q[0]); end
            end
            psh  = 1'($urandom_range(0, 1));
            rdy  = (n < 80) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
            stat = ($urandom_range(0, 3) == 0);
            b    = 8'($urandom);
            drive(A_DBG, stat, psh, {24'($urandom), b});
            dbg_tx_ready = rdy;
            full_pre = (q.size() == DEPTH);
            exp_stat = {27'd0, 4'(q.size()), full_pre};
            pop = rdy && (q.size() != 0);
            if (pop) void'(q.pop_front());
            if (psh && (!full_pre || pop)) q.push_back(b);
            tick();
            if (stat) begin
                checks++; if (mem_if.data_memory_read_data !== exp_stat) begin failures++; $display("FAIL frand_status n=%0d got=%h exp=%h", n, mem_if.data_memory_read_data, exp_stat); end
            end
        end
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        dbg_tx_ready = 1'b1;
        for (int t = 0; t < 20 && dbg_tx_valid; t++) tick();
        checks++; if (dbg_tx_valid !== 1'b0) begin failures++; $display("FAIL frand_drain_timeout got=%b exp=0", dbg_tx_valid); end
    endtask

    task automatic test_counter();
        logic [31:0] v1;
        drive(A_CYC_LO, 1'b1, 1'b0, 32'h0);
        tick();
        v1 = mem_if.data_memory_read_data;
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        repeat (6) tick();
        drive(A_CYC_LO, 1'b1, 1'b0, 32'h0);
        tick();
        checks++; if (mem_if.data_memory_read_data - v1 !== 32'd7) begin failures++; $display("FAIL cyc_delta got=%0d exp=7", mem_if.data_memory_read_data - v1); end
        // low word about to carry into the high word
        force dut.cyc_cnt_r = 64'h0000_0000_FFFF_FFFF;
        #1 release dut.cyc_cnt_r;
        drive(A_CYC_LO, 1'b1, 1'b0, 32'h0);
        tick();
        checks++; if (mem_if.data_memory_read_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL cyc_lo_carry got=%h exp=ffffffff", mem_if.data_memory_read_data); end
        drive(A_CYC_HI, 1'b1, 1'b0, 32'h0);
        tick();
        checks++; if (mem_if.data_memory_read_data !== 32'h0) begin failures++; $display("FAIL cyc_hi_shadow got=%h exp=0", mem_if.data_memory_read_data); end
        drive(A_CYC_LO, 1'b1, 1'b0, 32'h0);
        tick();
        checks++; if (mem_if.data_memory_read_data !== 32'h1) begin failures++; $display("FAIL cyc_lo_after got=%h exp=1", mem_if.data_memory_read_data); end
        drive(A_CYC_HI, 1'b1, 1'b0, 32'h0);
        tick();
        checks++; if (mem_if.data_memory_read_data !== 32'h1) begin failures++; $display("FAIL cyc_hi_after got=%h exp=1", mem_if.data_memory_read_data); end
        // full 64-bit wrap
        force dut.cyc_cnt_r = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.cyc_cnt_r;
        drive(A_CYC_LO, 1'b1, 1'b0, 32'h0);
        tick();
        checks++; if (mem_if.data_memory_read_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL cyc_max_lo got=%h exp=ffffffff", mem_if.data_memory_read_data); end
        drive(A_CYC_LO, 1'b1, 1'b0, 32'h0);
        tick();
        checks++; if (mem_if.data_memory_read_data !== 32'h0) begin failures++; $display("FAIL cyc_wrap_lo got=%h exp=0", mem_if.data_memory_read_data); end
        drive(A_CYC_HI, 1'b1, 1'b0, 32'h0);
        tick();
        checks++; if (mem_if.data_memory_read_data !== 32'h0) begin failures++; $display("FAIL cyc_wrap_hi got=%h exp=0", mem_if.data_memory_read_data); end
        drive(32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_bus_error_reset();
        checks++; if (bus_error !== 1'b0) begin failures++; $display("FAIL buserr_clean got=%b exp=0", bus_error); end
        drive(32'h10, 1'b1, 1'b0, 32'h0);
        tick();
        drive(32'h8000_0000, 1'b1, 1'b0, 32'h0);
        tick();
        checks++; if (mem_if.data_memory_read_data !== 32'h0) begin failures++; $display("FAIL oor_load got=%h exp=0", mem_if.data_memory_read_data); end
        checks++; if (bus_error !== 1'b1) begin failures++; $display("FAIL buserr_set got=%b exp=1", bus_error); end
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        repeat (3) tick();
        checks++; if (bus_error !== 1'b1) begin failures++; $display("FAIL buserr_sticky got=%b exp=1", bus_error); end
        mem_if.instruction_memory_address = 32'h0000_4000;
        tick();
        checks++; if (mem_if.instruction_memory_instruction !== NOP) begin failures++; $display("FAIL oor_fetch got=%h exp=%h", mem_if.instruction_memory_instruction, NOP); end
        mem_if.instruction_memory_address = 32'h10;
        // reset in the middle of a FIFO drain
        dbg_tx_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(A_DBG, 1'b0, 1'b1, 32'h60 + 32'(k));
            tick();
        end
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        dbg_tx_ready = 1'b1;
        tick();
        checks++; if (dbg_tx_valid !== 1'b1 || dbg_tx_data !== 8'h61) begin failures++; $display("FAIL drain_mid got=%b/%h exp=1/61", dbg_tx_valid, dbg_tx_data); end
        reset_n = 1'b0;
        #1;
        checks++; if (dbg_tx_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", dbg_tx_valid); end
        checks++; if (bus_error !== 1'b0) begin failures++; $display("FAIL rst_buserr got=%b exp=0", bus_error); end
        checks++; if (gpio_out !== 32'h0) begin failures++; $display("FAIL rst_gpio got=%h exp=0", gpio_out); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        checks++; if (dbg_tx_valid !== 1'b0) begin failures++; $display("FAIL rst_fifo_discard got=%b exp=0", dbg_tx_valid); end
        drive(32'h10, 1'b1, 1'b0, 32'h0);
        tick();
        checks++; if (mem_if.data_memory_read_data !== ram_m[32'h10 >> 2]) begin failures++; $display("FAIL ram_survives_reset got=%h exp=%h", mem_if.data_memory_read_data, ram_m[32'h10 >> 2]); end
        drive(32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_rw_same_cycle();
        test_random_ram();
        test_gpio();
        test_fifo_fill_drain();
        test_fifo_random();
        test_counter();
        test_bus_error_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
